// File: rtl/rptr_empty_level_if.sv
// Read-side FIFO pointer bundle: read request and synchronised write pointer in, address/pointer/flags out.
// master drives the request side; slave is the pointer/flag generator.
interface rptr_empty_level_if #(
    parameter int ASIZE = 3
);
    logic             rinc;
    logic [ASIZE:0]   rq2_wptr;
    logic [ASIZE-1:0] raddr;
    logic [ASIZE:0]   rptr;
    logic             rempty;
    logic             raempty;
    logic [ASIZE:0]   rlevel;
    logic             runderflow;

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, raempty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, raempty, rlevel, runderflow
    );
endinterface

// File: rtl/rptr_empty_level.sv
// Async-FIFO read pointer with empty, almost-empty, level and underflow flags; flags registered, raddr zero-latency.
// Reads while empty are refused (pointer holds) and reported as a one-cycle runderflow pulse.
module rptr_empty_level #(
    parameter int ASIZE     = 3,
    parameter int AE_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    rptr_empty_level_if.slave    bus
);
    localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_THRESH);

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbin_next;
    logic [ASIZE:0] rgray_next;
    logic [ASIZE:0] wbin;
    logic [ASIZE:0] level_next;
    logic [ASIZE:0] rptr_q;
    logic [ASIZE:0] rlevel_q;
    logic           rempty_q;
    logic           raempty_q;
    logic           runderflow_q;
    logic           accept;

    assign accept     = bus.rinc & ~rempty_q;
    assign rbin_next  = rbin + {{ASIZE{1'b0}}, accept};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            wbin[i] = ^(bus.rq2_wptr >> i);
        end
    end

    assign level_next = wbin - rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin         <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            rlevel_q     <= '0;
            runderflow_q <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr_q       <= rgray_next;
            rempty_q     <= (rgray_next == bus.rq2_wptr);
            raempty_q    <= (level_next <= AE_LVL);
            rlevel_q     <= level_next;
            runderflow_q <= bus.rinc & rempty_q;
        end
    end

    assign bus.raddr      = rbin[ASIZE-1:0];
    assign bus.rptr       = rptr_q;
    assign bus.rempty     = rempty_q;
    assign bus.raempty    = raempty_q;
    assign bus.rlevel     = rlevel_q;
    assign bus.runderflow = runderflow_q;
endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed plus randomized bench for rptr_empty_level, checked against a write/read counter model.
module tb_rptr_empty_level;
    localparam int ASIZE = 3;
    localparam int AE    = 2;
    localparam int DEPTH = 1 << ASIZE;

    logic rclk;
    logic rrst_n;

    rptr_empty_level_if #(.ASIZE(ASIZE)) bus ();

    rptr_empty_level #(.ASIZE(ASIZE), .AE_THRESH(AE)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int checks   = 0;
    int failures = 0;

    // Model: total words written and read since reset; everything else follows from them.
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit m_empty = 1'b1;
    bit m_uflow = 1'b0;

    function automatic int gray(input int n);
        int b;
        b = n % (2 * DEPTH);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int lvl;
        lvl = wr_cnt - rd_cnt;
        check("rptr",       int'(bus.rptr),       gray(rd_cnt));
        check("raddr",      int'(bus.raddr),      rd_cnt % DEPTH);
        check("rlevel",     int'(bus.rlevel),     lvl);
        check("rempty",     int'(bus.rempty),     (lvl == 0) ? 1 : 0);
        check("raempty",    int'(bus.raempty),    (lvl <= AE) ? 1 : 0);
        check("runderflow", int'(bus.runderflow), m_uflow ? 1 : 0);
    endtask

    task automatic step(input logic ri, input int wadd);
        @(negedge rclk);
        bus.rinc     = ri;
        wr_cnt       = wr_cnt + wadd;
        bus.rq2_wptr = 4'(gray(wr_cnt));
        @(posedge rclk);
        m_uflow = ri && m_empty;
        if (ri && !m_empty) rd_cnt++;
        m_empty = (wr_cnt == rd_cnt);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge rclk);
        #1 rrst_n = 1'b0;
        #1;
        check("rst_rptr",    int'(bus.rptr),       0);
        check("rst_raddr",   int'(bus.raddr),      0);
        check("rst_rempty",  int'(bus.rempty),     1);
        check("rst_raempty", int'(bus.raempty),    1);
        check("rst_rlevel",  int'(bus.rlevel),     0);
        check("rst_uflow",   int'(bus.runderflow), 0);
        wr_cnt = 0;
        rd_cnt = 0;
        m_empty = 1'b1;
        m_uflow = 1'b0;
        bus.rinc = 1'b0;
        bus.rq2_wptr = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        rrst_n       = 1'b1;
        bus.rinc     = 1'b0;
        bus.rq2_wptr = '0;

        // Reset asserted between edges must take effect with no clock edge.
        #2 rrst_n = 1'b0;
        #1;
        check("init_rptr",    int'(bus.rptr),    0);
        check("init_rempty",  int'(bus.rempty),  1);
        check("init_raempty", int'(bus.raempty), 1);
        check("init_rlevel",  int'(bus.rlevel),  0);
        @(negedge rclk);
        rrst_n = 1'b1;

        // Fill to 3, then drain with raddr 1/2/3.
        step(1'b0, 3);
        step(1'b1, 0);
        step(1'b1, 0);
        step(1'b1, 0);
        check("drain_raddr3", int'(bus.raddr), 3);

        // Underflow: two refused reads, then idle.
        step(1'b1, 0);
        step(1'b1, 0);
        step(1'b0, 0);

        // Wrap: 16 interleaved write/read pairs from a clean reset.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1);
            step(1'b1, 0);
            if (i == 8) begin
                check("wrap8_rptr",  int'(bus.rptr),  4'b1100);
                check("wrap8_raddr", int'(bus.raddr), 0);
            end
        end
        check("wrap16_rptr",   int'(bus.rptr),   0);
        check("wrap16_rempty", int'(bus.rempty), 1);

        // Full level, then write and read in the same cycle.
        do_reset();
        step(1'b0, 8);
        check("full_rlevel", int'(bus.rlevel), 8);
        step(1'b1, 1);
        check("simul_rlevel", int'(bus.rlevel), 8);

        // Random traffic, keeping occupancy within the FIFO depth.
        for (int i = 0; i < 300; i++) begin
            int wadd;
            wadd = int'($urandom_range(0, 2));
            if (wr_cnt + wadd - rd_cnt > DEPTH) wadd = DEPTH - (wr_cnt - rd_cnt);
            step(1'($urandom_range(0, 1)), wadd);
        end

        // Reset mid-drain with a non-empty write pointer still applied.
        step(1'b0, 4);
        step(1'b1, 0);
        do_reset();
        step(1'b0, 2);
        step(1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rptr_empty_level.md
RPTR_EMPTY_LEVEL -- requirements
Module: rptr_empty_level

Interface
REQ-001 The block SHALL have parameter ASIZE, default 3, giving the FIFO address width; depth is 2**ASIZE and pointers are ASIZE+1 bits.
REQ-002 The block SHALL have parameter AE_THRESH, default 2, the almost-empty level threshold, legal range 0 to 2**ASIZE-1.
REQ-003 The block SHALL have port rclk, input, 1 bit: read-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rrst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port rinc, input, 1 bit: read request.
REQ-006 The block SHALL have port rq2_wptr, input, ASIZE+1 bits: Gray-coded write pointer, already synchronised into rclk.
REQ-007 The block SHALL have port raddr, output, ASIZE bits: RAM read address.
REQ-008 The block SHALL have port rptr, output, ASIZE+1 bits: registered Gray read pointer for the write domain.
REQ-009 The block SHALL have port rempty, output, 1 bit: FIFO empty.
REQ-010 The block SHALL have port raempty, output, 1 bit: level at or below AE_THRESH.
REQ-011 The block SHALL have port rlevel, output, ASIZE+1 bits: occupancy seen by the read side, 0 to 2**ASIZE.
REQ-012 The block SHALL have port runderflow, output, 1 bit: one-cycle pulse on a rejected read.

Function
REQ-013 The block SHALL accept a read only when rinc=1 and rempty=0; rbinnext = rbin + accepted, modulo 2**(ASIZE+1).
REQ-014 The block SHALL compute rgraynext = (rbinnext >> 1) XOR rbinnext and register rbin<=rbinnext, rptr<=rgraynext each cycle.
REQ-015 The block SHALL drive raddr = rbin[ASIZE-1:0] combinationally from the registered binary pointer, with zero added latency.
REQ-016 The block SHALL register rempty <= (rgraynext == rq2_wptr), so empty asserts in the same edge that consumes the last word.
REQ-017 The block SHALL convert rq2_wptr to binary wbin (bit i = XOR of bits ASIZE..i) combinationally.
REQ-018 The block SHALL register rlevel <= (wbin - rbinnext) modulo 2**(ASIZE+1), a value in 0 to 2**ASIZE.
REQ-019 The block SHALL register raempty <= ((wbin - rbinnext) <= AE_THRESH), updated on the same edge as rlevel.
REQ-020 The block SHALL register runderflow <= rinc AND rempty; pointers SHALL NOT advance on that cycle.
REQ-021 Pointer wrap-around from 2**(ASIZE+1)-1 to 0 SHALL be seamless: MSB toggles, raddr returns to 0, and rempty/rlevel stay correct.
REQ-022 When rq2_wptr changes in the same cycle as an accepted read, all flags SHALL reflect both events in the next registered values.
REQ-023 rptr SHALL change by at most one bit per rclk cycle.

Reset
REQ-024 While rrst_n=0, the block SHALL immediately and asynchronously force: rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, runderflow=0; raddr=0 follows.
REQ-025 On reset release, the first update SHALL occur on the first rising rclk edge after rrst_n=1.
REQ-026 Reset asserted mid-operation SHALL discard in-flight state with no partial update; flags return to the empty state regardless of rq2_wptr.

Verification (ASIZE=3, AE_THRESH=2)
REQ-027 Reset check: assert rrst_n=0 between edges -> outputs show rptr=0000, rempty=1, raempty=1, rlevel=0 without a clock edge.
REQ-028 Fill/drain check: rq2_wptr=0010 (bin 3), rinc=0 -> next edge rempty=0, rlevel=3, raempty=0. Then rinc=1 for 3 cycles -> rlevel 2/1/0, raempty=1 from the first read, rempty=1 after the third read, raddr 1/2/3.
REQ-029 Underflow check: hold rinc=1 while rempty=1 -> runderflow=1 for exactly the cycles requested, and rptr/raddr stay unchanged.
REQ-030 Wrap check: 16 writes and reads interleaved -> rptr follows the Gray sequence; after the 8th read rptr=1100 and raddr=000; after the 16th, rptr=0000 with rempty=1.
REQ-031 Full-level check: rptr=0, rq2_wptr=1100 (bin 8) -> rlevel=8, rempty=0, raempty=0.
REQ-032 Simultaneous-event and reset check: advance rq2_wptr and read in one cycle -> rlevel unchanged. Assert rrst_n=0 mid-drain -> immediate empty state.
